pc_sequencer: RTL

- Parametrised successor to the single-source PC register, sitting at the head of the fetch stage.
- Holds the program counter and selects the next fetch address from four sources: sequential, branch/jump redirect, return-address stack (RAS) prediction, and the exception vector.
- Adds stall, misaligned-target trapping and a circular RAS with overflow reporting.

---
 rtl/pc_pkg.sv | 10 +
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_sequencer.sv | 77 +++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and next-PC source encoding for the fetch-stage PC sequencer.
package pc_pkg;
    localparam int          DEF_WIDTH        = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int          DEF_STEP         = 4;
    localparam int          DEF_RAS_DEPTH    = 4;

    typedef enum logic [1:0] {SEL_SEQ, SEL_NEW, SEL_RAS, SEL_EXC} pc_sel_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
// and sets a sticky overflow flag; push+pop together replaces the top entry.
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             overflow
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx, wr_idx;
    logic [PW:0]      occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic             full, do_pop, push_only, pop_only;

    assign top_idx   = ptr_q - PW'(1);
    assign empty     = occ_q == '0;
    assign full      = occ_q == (PW+1)'(RAS_DEPTH);
    assign do_pop    = pop & ~empty;
    assign push_only = push & ~do_pop;
    assign pop_only  = do_pop & ~push;
    assign top       = mem_q[top_idx];
    assign overflow  = ovf_q;
    // A combined push+pop rewrites the current top slot in place.
    assign wr_idx    = do_pop ? top_idx : ptr_q;

    always_comb begin
        ptr_d = push_only ? ptr_q + PW'(1) : pop_only ? top_idx : ptr_q;
        occ_d = push_only ? (full ? occ_q : occ_q + (PW+1)'(1)) : pop_only ? occ_q - (PW+1)'(1) : occ_q;
        ovf_d = ovf_q | (push_only & full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= pushData;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with priority next-PC selection
// (exception, RAS return, redirect, sequential), stall and misaligned-redirect trapping.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               STEP         = DEF_STEP,
    parameter bit               DELAY_SLOT   = 1'b0,
    parameter int               RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count,
    input  logic             shouldUseNewPC,
    input  logic [WIDTH-1:0] newPC,
    input  logic             exception,
    input  logic             isCall,
    input  logic             isReturn,
    output logic [WIDTH-1:0] pcAddress,
    output logic [WIDTH-1:0] nextPCAddress,
    output logic             rasEmpty,
    output logic             rasOverflow,
    output logic             misaligned
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    localparam logic [WIDTH-1:0] RET_OFFSET = WIDTH'(DELAY_SLOT ? 2 * STEP : STEP);

    logic [WIDTH-1:0] pc_q, pc_d, ras_top;
    logic             mis_q, mis_d;
    logic             take_ret, misal, ras_push, ras_pop;
    pc_sel_t          sel;

    assign pcAddress     = pc_q;
    assign nextPCAddress = pc_q + WIDTH'(STEP);
    assign misaligned    = mis_q;

    always_comb begin
        take_ret = isReturn & ~rasEmpty;
        sel      = exception ? SEL_EXC : take_ret ? SEL_RAS : shouldUseNewPC ? SEL_NEW : SEL_SEQ;
        misal    = (sel == SEL_NEW) ? |(newPC & ALIGN_MASK) : 1'b0;
        // A trapped redirect must not leave a return address behind.
        ras_push = count & isCall & ~exception & ~misal;
        ras_pop  = count & take_ret & ~exception;
        mis_d    = count & misal;
        pc_d     = !count                         ? pc_q :
                   (sel == SEL_EXC) || misal      ? EXC_VECTOR :
                   (sel == SEL_RAS)               ? ras_top :
                   (sel == SEL_NEW)               ? newPC :
                                                    nextPCAddress;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .pushData (pc_q + RET_OFFSET),
        .top      (ras_top),
        .empty    (rasEmpty),
        .overflow (rasOverflow)
    );
endmodule
